// File: rtl/instr_fetch_pkg.sv
// Shared defaults and the buffered fetch entry type for the fetch stage.
package instr_fetch_pkg;

  localparam int unsigned DEF_PTR_WIDTH        = 8;
  localparam int unsigned DEF_INSTR_WIDTH      = 128;
  localparam int unsigned DEF_MEM_READ_LATENCY = 2;
  localparam int unsigned DEF_FIFO_DEPTH       = 4;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [DEF_INSTR_WIDTH-1:0] instr;
    logic [DEF_PTR_WIDTH-1:0]   addr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Memory read bus plus decoder valid/ready handshake of the fetch stage.
// master = fetch unit, slave = memory/decoder environment.
interface instr_fetch_if import instr_fetch_pkg::*; #(
  parameter int unsigned PTR_WIDTH   = DEF_PTR_WIDTH,
  parameter int unsigned INSTR_WIDTH = DEF_INSTR_WIDTH
) ();

  logic                   mem_rd_en;
  logic [PTR_WIDTH-1:0]   mem_addr;
  logic [INSTR_WIDTH-1:0] mem_rd_data;
  logic [INSTR_WIDTH-1:0] instr_out;
  logic [PTR_WIDTH-1:0]   instr_addr;
  logic                   instr_valid;
  logic                   instr_ready;

  modport master (
    output mem_rd_en, mem_addr, instr_out, instr_addr, instr_valid,
    input  mem_rd_data, instr_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, instr_out, instr_addr, instr_valid,
    output mem_rd_data, instr_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding returned fetches; clear drops everything and wins over push.
module fetch_fifo import instr_fetch_pkg::*; #(
  parameter int unsigned DEPTH   = DEF_FIFO_DEPTH,
  parameter type         entry_t = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic                       push,
  input  entry_t                     push_data,
  input  logic                       pop,
  output entry_t                     head,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic          full, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rd_q];
  assign count   = count_q;

  // Pointer and occupancy state; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (clear) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: slots are only observed while count covers them.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_q] <= push_data;
  end

  // Upstream credit accounting must never push into a full FIFO without a pop.
  overflow_check: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && !clear && full && !pop));

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: issues fixed-latency memory reads while credit remains, tracks them
// in a latency-matched shift register and buffers returns for the decoder.
module instr_fetch import instr_fetch_pkg::*; #(
  parameter int unsigned PTR_WIDTH        = DEF_PTR_WIDTH,
  parameter int unsigned INSTR_WIDTH      = DEF_INSTR_WIDTH,
  parameter int unsigned MEM_READ_LATENCY = DEF_MEM_READ_LATENCY,
  parameter int unsigned FIFO_DEPTH       = DEF_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 run,
  input  logic                 flush,
  input  logic [PTR_WIDTH-1:0] ptr_in,
  output logic                 ptr_enable,
  instr_fetch_if.master        bus
);

  localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TW  = $clog2(FIFO_DEPTH + MEM_READ_LATENCY + 1);
  localparam int unsigned LAT = MEM_READ_LATENCY;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [PTR_WIDTH-1:0]   addr;
  } entry_t;

  logic [LAT-1:0]                sr_valid_q, sr_valid_d;
  logic [LAT-1:0][PTR_WIDTH-1:0] sr_addr_q, sr_addr_d;
  logic [TW-1:0]                 inflight;
  logic [CW-1:0]                 occupancy;
  logic                          issue, push, pop, fifo_empty;
  entry_t                        push_entry, head;

  // Count reads still travelling through memory.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(LAT); i++) inflight = inflight + TW'(sr_valid_q[i]);
  end

  // Credit check; reset_n gates issue so nothing leaves while reset is held.
  assign issue = reset_n & run & ~flush &
                 ((inflight + TW'(occupancy)) < TW'(FIFO_DEPTH));

  // Shift register next state; flush kills every in-flight read.
  always_comb begin
    sr_valid_d = '0;
    sr_addr_d  = sr_addr_q;
    if (!flush) begin
      sr_valid_d[0] = issue;
      sr_addr_d[0]  = ptr_in;
      for (int i = 1; i < int'(LAT); i++) begin
        sr_valid_d[i] = sr_valid_q[i-1];
        sr_addr_d[i]  = sr_addr_q[i-1];
      end
    end
  end

  // In-flight read tracking register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_valid_q <= '0;
      sr_addr_q  <= '0;
    end else begin
      sr_valid_q <= sr_valid_d;
      sr_addr_q  <= sr_addr_d;
    end
  end

  assign push             = sr_valid_q[LAT-1];
  assign push_entry.instr = bus.mem_rd_data;
  assign push_entry.addr  = sr_addr_q[LAT-1];
  assign pop              = bus.instr_valid & bus.instr_ready;

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (flush),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .count     (occupancy)
  );

  assign ptr_enable      = issue;
  assign bus.mem_rd_en   = issue;
  assign bus.mem_addr    = issue ? ptr_in : '0;
  assign bus.instr_valid = ~fifo_empty & ~flush;
  assign bus.instr_out   = fifo_empty ? '0 : head.instr;
  assign bus.instr_addr  = fifo_empty ? '0 : head.addr;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: pointer and memory models, a queue-based reference of
// outstanding fetches checked every cycle, directed scenarios and a random phase.
module tb_instr_fetch;

  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         run, flush, ready, load, ptr_enable;
  logic [7:0]   ptr, load_val;
  logic [127:0] junk;
  logic         mp_v [LAT];
  logic [7:0]   mp_a [LAT];
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;

  typedef struct {
    int         rdy;
    logic [7:0] addr;
  } exp_t;

  exp_t         q[$];
  logic [7:0]   out_addr[$];
  logic [127:0] out_data[$];
  int           out_cyc[$];
  logic [7:0]   issue_addr[$];
  int           issue_cyc[$];
  logic         m_issue, m_valid;

  instr_fetch_if #(.PTR_WIDTH(8), .INSTR_WIDTH(128)) bus ();

  instr_fetch #(
    .PTR_WIDTH        (8),
    .INSTR_WIDTH      (128),
    .MEM_READ_LATENCY (LAT),
    .FIFO_DEPTH       (DEPTH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .run        (run),
    .flush      (flush),
    .ptr_in     (ptr),
    .ptr_enable (ptr_enable),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for instr_ptr: load wins, otherwise advance on enable.
  always @(posedge clk) begin
    if (load) ptr <= load_val;
    else if (ptr_enable) ptr <= ptr + 8'd1;
  end

  // Memory: data = 0x1000 + addr exactly LAT cycles after the strobe, junk otherwise.
  always @(posedge clk) begin
    mp_v[0] <= bus.mem_rd_en;
    mp_a[0] <= bus.mem_addr;
    for (int i = 1; i < int'(LAT); i++) begin
      mp_v[i] <= mp_v[i-1];
      mp_a[i] <= mp_a[i-1];
    end
    junk <= {$urandom, $urandom, $urandom, $urandom};
  end

  assign bus.mem_rd_data = mp_v[LAT-1] ? (128'h1000 + 128'(mp_a[LAT-1])) : junk;
  assign bus.instr_ready = ready;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: outstanding fetches in issue order, each visible LAT+1 cycles after issue.
  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      chk("rst_ptr_enable", ptr_enable, 0);
      chk("rst_mem_rd_en", bus.mem_rd_en, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_instr_valid", bus.instr_valid, 0);
      chk("rst_instr_out", bus.instr_out, 0);
      chk("rst_instr_addr", bus.instr_addr, 0);
    end else begin
      m_issue = run && !flush && (q.size() < int'(DEPTH));
      m_valid = !flush && (q.size() != 0) && (q[0].rdy <= cyc);
      chk("ptr_enable", ptr_enable, m_issue);
      chk("mem_rd_en", bus.mem_rd_en, m_issue);
      if (m_issue) chk("mem_addr", bus.mem_addr, ptr);
      chk("instr_valid", bus.instr_valid, m_valid);
      if (m_valid) begin
        chk("instr_addr", bus.instr_addr, q[0].addr);
        chk("instr_out", bus.instr_out, 128'h1000 + 128'(q[0].addr));
      end
      if (m_valid && ready) begin
        out_addr.push_back(bus.instr_addr);
        out_data.push_back(bus.instr_out);
        out_cyc.push_back(cyc);
        void'(q.pop_front());
      end
      if (m_issue) begin
        issue_addr.push_back(ptr);
        issue_cyc.push_back(cyc);
        q.push_back('{rdy: cyc + int'(LAT) + 1, addr: ptr});
      end
      if (flush) q.delete();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    out_addr.delete();
    out_data.delete();
    out_cyc.delete();
    issue_addr.delete();
    issue_cyc.delete();
  endtask

  task automatic do_reset(input logic [7:0] start);
    reset_n  = 1'b0;
    flush    = 1'b0;
    load     = 1'b1;
    load_val = start;
    tick();
    tick();
    load    = 1'b0;
    reset_n = 1'b1;
    clear_logs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int idx;
    int bad;
    bit found;
    run = 1'b1; flush = 1'b0; ready = 1'b1; load = 1'b1; load_val = 8'h00;
    #2 reset_n = 1'b0;

    // Reset held with run high: nothing leaves, then streaming from address 0.
    tick(); tick(); tick();
    chk("reset_hold_ptr_enable", ptr_enable, 0);
    chk("reset_hold_mem_rd_en", bus.mem_rd_en, 0);
    load = 1'b0; reset_n = 1'b1; clear_logs();
    repeat (20) tick();
    chk("first_issue_addr", issue_addr[0], 8'h00);
    chk("stream_len_ok", out_addr.size() >= 8, 1);
    chk("first_out_latency", 128'(out_cyc[0] - issue_cyc[0]), 3);
    chk("first_out_addr", out_addr[0], 8'h00);
    chk("first_out_data", out_data[0], 128'h1000);
    for (int i = 1; i < 8; i++) begin
      chk("stream_addr", out_addr[i], 128'(i));
      chk("stream_no_bubble", 128'(out_cyc[i] - out_cyc[i-1]), 1);
    end

    // Backpressure: exactly DEPTH issues, then drain in order.
    ready = 1'b0;
    do_reset(8'h00);
    repeat (10) tick();
    chk("bp_issue_count", issue_addr.size(), DEPTH);
    for (int i = 0; i < 4; i++) chk("bp_issue_addr", issue_addr[i], 128'(i));
    chk("bp_ptr_hold", ptr, 8'h04);
    ready = 1'b1;
    repeat (15) tick();
    chk("bp_len_ok", out_addr.size() >= 8, 1);
    for (int i = 0; i < 8; i++) chk("bp_out_addr", out_addr[i], 128'(i));

    // Flush while 5 and 6 are in flight, jumping to 0x40.
    do_reset(8'h00);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (issue_addr.size() != 0 && issue_addr[issue_addr.size()-1] == 8'd6) found = 1'b1;
    end
    chk("flush_wait_addr6", found, 1);
    flush = 1'b1; load = 1'b1; load_val = 8'h40;
    tick();
    flush = 1'b0; load = 1'b0;
    repeat (12) tick();
    bad = 0;
    foreach (out_addr[i]) if (out_addr[i] == 8'd5 || out_addr[i] == 8'd6) bad++;
    chk("flush_killed_absent", bad, 0);
    chk("flush_len_ok", out_addr.size() >= 5, 1);
    chk("flush_next_addr", out_addr[4], 8'h40);
    chk("flush_next_data", out_data[4], 128'h1040);

    // Address wrap is forwarded unchanged.
    do_reset(8'hFE);
    repeat (10) tick();
    chk("wrap_addr0", out_addr[0], 8'hFE);
    chk("wrap_addr1", out_addr[1], 8'hFF);
    chk("wrap_addr2", out_addr[2], 8'h00);
    chk("wrap_addr3", out_addr[3], 8'h01);

    // Reset with two buffered entries and two reads in flight.
    ready = 1'b0;
    do_reset(8'h00);
    repeat (4) tick();
    chk("pre_reset_valid", bus.instr_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("reset_drops_valid", bus.instr_valid, 0);
    tick();
    reset_n = 1'b1;
    clear_logs();
    ready = 1'b1;
    repeat (10) tick();
    chk("post_reset_len_ok", out_addr.size() >= 2, 1);
    chk("post_reset_addr", out_addr[0], 8'h04);
    chk("post_reset_data", out_data[0], 128'h1004);
    idx = 0;
    foreach (out_addr[i]) if (out_addr[i] < 8'd4) idx++;
    chk("post_reset_no_stale", idx, 0);

    // Random run/ready/flush/reset traffic against the reference.
    do_reset(8'($urandom));
    for (int i = 0; i < 500; i++) begin
      reset_n = ($urandom_range(0, 79) != 0);
      run     = ($urandom_range(0, 3) != 0);
      ready   = $urandom_range(0, 1);
      if (reset_n && $urandom_range(0, 11) == 0) begin
        flush = 1'b1; load = 1'b1; load_val = 8'($urandom);
      end else begin
        flush = 1'b0; load = 1'b0;
      end
      tick();
    end
    reset_n = 1'b1; flush = 1'b0; load = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Fetch stage directly downstream of instr_ptr. It consumes the pointer value (ptr_out), issues fixed-latency reads to instruction memory and buffers the returned words in a small FIFO. It presents instructions to the decoder with a valid/ready handshake. It drives instr_ptr's enable, so the pointer advances only when a fetch is actually issued, and it discards in-flight fetches on a pointer load (jump).

Parameters:
PTR_WIDTH, 8, instruction address width; matches instr_ptr.
INSTR_WIDTH, 128, instruction word width.
MEM_READ_LATENCY, 2, cycles from mem_rd_en to valid mem_rd_data; must be >= 1.
FIFO_DEPTH, 4, buffer entries; power of 2; must be >= MEM_READ_LATENCY+2 for 1 instr/cycle.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
run  in  1  fetch permitted while high
flush  in  1  pulse in the same cycle as instr_ptr load_enable; kills in-flight and buffered fetches
ptr_in  in  PTR_WIDTH  current instr_ptr ptr_out
ptr_enable  out  1  to instr_ptr enable; high exactly in issue cycles
mem_rd_en  out  1  memory read strobe
mem_addr  out  PTR_WIDTH  memory read address
mem_rd_data  in  INSTR_WIDTH  read data, valid MEM_READ_LATENCY cycles after mem_rd_en
instr_out  out  INSTR_WIDTH  FIFO head instruction
instr_addr  out  PTR_WIDTH  address of instr_out
instr_valid  out  1  head valid
instr_ready  in  1  decoder accepts

Behaviour:
- Reset (async assert, sync release): in-flight shift register cleared, FIFO empty, counters 0; ptr_enable=0, mem_rd_en=0, mem_addr=0, instr_valid=0, instr_out=0, instr_addr=0.
- Issue condition (combinational): issue = run & ~flush & (inflight + occupancy < FIFO_DEPTH). A pop in the same cycle does not count as credit.
- Issue cycle: mem_rd_en=1, mem_addr=ptr_in, ptr_enable=1. instr_ptr advances on the next edge, so back-to-back issues fetch consecutive addresses.
- In-flight tracking: MEM_READ_LATENCY-deep shift register of {valid, addr}. An entry exiting the shift register with valid=1 pushes {mem_rd_data, addr} into the FIFO at that edge.
- Latency: issue in cycle t -> instr_valid in cycle t+MEM_READ_LATENCY+1 (3 at default).
- Output: instr_valid = ~fifo_empty & ~flush. Pop on instr_valid & instr_ready. Output order equals issue order.
- Simultaneous push and pop: both occur and occupancy is unchanged. The credit check prevents a FIFO overflow by construction; the implementation asserts that overflow never happens.
- Flush: in the flush cycle there is no issue, ptr_enable=0 and instr_valid=0, so no handshake occurs. On the following edge all shift-register valid bits and the FIFO are cleared, so data returning from killed reads is dropped. The first issue after flush uses the loaded pointer value.
- run low: no new issues. In-flight reads still complete and the FIFO still drains.
- Address wrap: the pointer wraps 2^PTR_WIDTH-1 -> 0 inside instr_ptr. This block forwards the address unchanged, with no special case.
- Reset mid-operation: all state is cleared immediately. In-flight memory responses after release are ignored because their valid bits are cleared.

Decomposition:
- Shared package: PTR_WIDTH and INSTR_WIDTH defaults, plus a fetch_entry_t struct {instr, addr} used by the FIFO and the decoder.
- One sub-module: fetch_fifo, a synchronous FIFO with push/pop/empty/count outputs, parameterised by depth and entry type, and using the same clk/reset_n.
- Credit logic and the latency shift register stay in instr_fetch.

Test Plan:
(The memory model returns data = 0x1000+addr after MEM_READ_LATENCY cycles; instr_ptr is instantiated and loads 0 at start.)
- Reset: hold reset_n=0 with run=1 -> ptr_enable, mem_rd_en and instr_valid stay 0. After release, the first mem_rd_en has mem_addr=0.
- Streaming: run=1, ready=1 -> instr_valid is first high 3 cycles after the first issue with instr_addr=0 and instr_out=0x1000. Then addresses 1,2,3,... follow on consecutive cycles with no bubbles.
- Backpressure: ready=0 from start -> exactly 4 issues (addr 0..3), then ptr_enable=0 and ptr holds at 4. Set ready=1 -> outputs 0,1,2,3,4,... with no loss or duplication.
- Flush: while addr 5,6 are in flight, pulse flush together with load_enable (load_val=0x40) -> addr 5 and 6 never appear at the output. The next instr_addr is 0x40 with instr_out=0x1040.
- Wrap: start the pointer at 0xFE -> output addresses 0xFE, 0xFF, 0x00, 0x01 in order.
- Mid-operation reset: assert reset_n=0 with 2 reads in flight and 2 entries buffered -> instr_valid drops immediately. After release, late memory data is not output and fetch restarts from the pointer value.
